// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM driving ALU opsel and datapath enables
// Build option MC_ILLEGAL_TRAP_EN: unknown opcode/funct halts with state_o=4'hF; otherwise it is a NOP.

package alu_pkg;
  typedef enum logic [4:0] {
    C_NOP   = 5'd0,
    C_ADD_U = 5'd1,
    C_SUB_U = 5'd2,
    C_MULT  = 5'd3,
    C_MUL_U = 5'd4,
    C_AND   = 5'd5,
    C_OR    = 5'd6,
    C_XOR   = 5'd7,
    C_SRL   = 5'd8,
    C_SLL   = 5'd9,
    C_SRA   = 5'd10,
    C_SLT   = 5'd11,
    C_SLTU  = 5'd12,
    C_MFHI  = 5'd13,
    C_MFLO  = 5'd14,
    C_JR    = 5'd15,
    C_BEQ   = 5'd16,
    C_BNE   = 5'd17,
    C_BLEZ  = 5'd18,
    C_BGTZ  = 5'd19
  } alu_sel_t;
endpackage

module mips_mc_ctrl
  import alu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] ir_opcode_i,
  input  logic [5:0] ir_funct_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  output logic [4:0] opsel_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic       pc_en_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       jump_and_link_o,
  output logic       hi_lo_write_o,
  output logic       halted_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [2:0] {K_R, K_I, K_MEM, K_BR, K_J, K_HALT, K_BAD} kind_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state_q;
  logic [5:0]    op_q, fn_q;
  logic          illegal_q;
  logic [CW-1:0] wait_q;

  kind_t    kind;
  alu_sel_t r_sel, i_sel, b_sel;
  logic     r_hilo, r_jr, mem_wait, timeout;

  // Decode works on the opcode/funct captured at the ir_write edge.
  always_comb begin
    kind = K_BAD;
    case (op_q)
      6'h00:                                    kind = K_R;
      6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B: kind = K_I;
      6'h23, 6'h2B:                             kind = K_MEM;
      6'h04, 6'h05, 6'h06, 6'h07:               kind = K_BR;
      6'h02, 6'h03:                             kind = K_J;
      6'h3F:                                    kind = K_HALT;
      default:                                  kind = K_BAD;
    endcase
    r_sel = C_NOP;
    case (fn_q)
      6'h21: r_sel = C_ADD_U;
      6'h23: r_sel = C_SUB_U;
      6'h18: r_sel = C_MULT;
      6'h19: r_sel = C_MUL_U;
      6'h24: r_sel = C_AND;
      6'h25: r_sel = C_OR;
      6'h26: r_sel = C_XOR;
      6'h02: r_sel = C_SRL;
      6'h00: r_sel = C_SLL;
      6'h03: r_sel = C_SRA;
      6'h2A: r_sel = C_SLT;
      6'h2B: r_sel = C_SLTU;
      6'h10: r_sel = C_MFHI;
      6'h12: r_sel = C_MFLO;
      6'h08: r_sel = C_JR;
      default: r_sel = C_NOP;
    endcase
    i_sel = C_NOP;
    case (op_q)
      6'h09: i_sel = C_ADD_U;
      6'h0C: i_sel = C_AND;
      6'h0D: i_sel = C_OR;
      6'h0E: i_sel = C_XOR;
      6'h0A: i_sel = C_SLT;
      6'h0B: i_sel = C_SLTU;
      default: i_sel = C_NOP;
    endcase
    case (op_q[1:0])
      2'd0:    b_sel = C_BEQ;
      2'd1:    b_sel = C_BNE;
      2'd2:    b_sel = C_BLEZ;
      default: b_sel = C_BGTZ;
    endcase
  end

  assign r_hilo   = (r_sel == C_MULT) || (r_sel == C_MUL_U);
  assign r_jr     = (r_sel == C_JR);
  assign mem_wait = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE}) && !mem_ready_i;
  assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && (wait_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      illegal_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      // Counter is zero whenever no wait is in progress, so every memory state starts from 0.
      wait_q <= mem_wait ? wait_q + CW'(1) : '0;
      if (timeout) begin
        state_q <= S_HALT;
      end else begin
        case (state_q)
          S_FETCH: if (mem_ready_i) begin
            state_q <= S_DECODE;
            op_q    <= ir_opcode_i;
            fn_q    <= ir_funct_i;
          end
          S_DECODE: begin
            case (kind)
              K_R:    state_q <= S_R_EXEC;
              K_I:    state_q <= S_I_EXEC;
              K_MEM:  state_q <= S_MEM_ADDR;
              K_BR:   state_q <= S_BRANCH;
              K_J:    state_q <= S_JUMP;
              K_HALT: state_q <= S_HALT;
              default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_q   <= S_HALT;
                illegal_q <= 1'b1;
`else
                state_q   <= S_FETCH;
`endif
              end
            endcase
          end
          S_R_EXEC: begin
            if (r_sel == C_NOP) begin
`ifdef MC_ILLEGAL_TRAP_EN
              state_q   <= S_HALT;
              illegal_q <= 1'b1;
`else
              state_q   <= S_FETCH;
`endif
            end else if (r_hilo || r_jr) begin
              state_q <= S_FETCH;
            end else begin
              state_q <= S_R_WB;
            end
          end
          S_I_EXEC:    state_q <= S_I_WB;
          S_MEM_ADDR:  state_q <= (op_q == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
          S_MEM_READ:  if (mem_ready_i) state_q <= S_MEM_WB;
          S_MEM_WRITE: if (mem_ready_i) state_q <= S_FETCH;
          S_HALT:      state_q <= S_HALT;
          default:     state_q <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    opsel_o         = C_NOP;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    pc_en_o         = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    jump_and_link_o = 1'b0;
    hi_lo_write_o   = 1'b0;
    halted_o        = 1'b0;
    state_o         = 4'h0;
    if (!rst_i) begin
      state_o = (state_q == S_HALT && illegal_q) ? 4'hF : state_q;
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          opsel_o     = C_ADD_U;
          ir_write_o  = mem_ready_i;
          pc_en_o     = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          opsel_o     = (kind == K_BAD) ? C_NOP : C_ADD_U;
        end
        S_R_EXEC: begin
          alu_src_a_o   = 1'b1;
          opsel_o       = r_sel;
          hi_lo_write_o = r_hilo;
          pc_en_o       = r_jr;
        end
        S_R_WB: begin
          opsel_o     = r_sel;
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          opsel_o     = i_sel;
        end
        S_I_WB:   reg_write_o = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          opsel_o     = C_ADD_U;
        end
        S_MEM_READ: begin
          i_or_d_o   = 1'b1;
          mem_read_o = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEM_WRITE: begin
          i_or_d_o    = 1'b1;
          mem_write_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          pc_source_o = 2'b01;
          opsel_o     = b_sel;
          pc_en_o     = branch_taken_i;
        end
        S_JUMP: begin
          pc_en_o         = 1'b1;
          pc_source_o     = 2'b10;
          reg_write_o     = (op_q == 6'h03);
          jump_and_link_o = (op_q == 6'h03);
        end
        S_HALT:   halted_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - randomized self-checking bench for mips_mc_ctrl against an instruction-level model
module tb_mips_mc_ctrl;
  import alu_pkg::*;

  localparam int TMO = 4;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [5:0] OP_TAB [16] = '{6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h23,
                                         6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h31};
  localparam logic [5:0] FN_TAB [15] = '{6'h21, 6'h23, 6'h18, 6'h19, 6'h24, 6'h25, 6'h26, 6'h02,
                                         6'h00, 6'h03, 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h08};

  logic       clk_i = 1'b0;
  logic       rst_i, branch_taken_i, mem_ready_i;
  logic [5:0] ir_opcode_i, ir_funct_i;
  logic [4:0] opsel_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [3:0] state_o;
  logic       alu_src_a_o, pc_en_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o;
  logic       reg_dst_o, mem_to_reg_o, jump_and_link_o, hi_lo_write_o, halted_o;

  always #5 clk_i = ~clk_i;

  mips_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_opcode_i(ir_opcode_i), .ir_funct_i(ir_funct_i),
    .branch_taken_i(branch_taken_i), .mem_ready_i(mem_ready_i), .opsel_o(opsel_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o),
    .pc_en_o(pc_en_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .jump_and_link_o(jump_and_link_o),
    .hi_lo_write_o(hi_lo_write_o), .halted_o(halted_o), .state_o(state_o)
  );

  typedef struct packed {
    logic [4:0] opsel;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, jal, hlw, halted;
  } ovec_t;

  typedef struct {
    ovec_t e;
    logic  rdy;
    logic  bt;
    string tag;
  } step_t;

  step_t sq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    m_halt, m_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic ovec_t observe();
    ovec_t v;
    v.opsel = opsel_o;       v.src_a = alu_src_a_o;      v.src_b = alu_src_b_o;
    v.pc_src = pc_source_o;  v.pc_en = pc_en_o;          v.i_or_d = i_or_d_o;
    v.mem_read = mem_read_o; v.mem_write = mem_write_o;  v.ir_write = ir_write_o;
    v.reg_write = reg_write_o; v.reg_dst = reg_dst_o;    v.mem_to_reg = mem_to_reg_o;
    v.jal = jump_and_link_o; v.hlw = hi_lo_write_o;      v.halted = halted_o;
    return v;
  endfunction

  function automatic ovec_t idle();
    ovec_t v = '0;
    v.opsel = C_NOP;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(input ovec_t e, input logic rdy, input logic bt, input string tag);
    step_t s;
    s.e = e; s.rdy = rdy; s.bt = bt; s.tag = tag;
    sq.push_back(s);
  endfunction

  function automatic int op_class(input logic [5:0] o);
    case (o)
      6'h00:                                    return 0;
      6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B: return 1;
      6'h23, 6'h2B:                             return 2;
      6'h04, 6'h05, 6'h06, 6'h07:               return 3;
      6'h02, 6'h03:                             return 4;
      6'h3F:                                    return 5;
      default:                                  return 6;
    endcase
  endfunction

  function automatic alu_sel_t r_map(input logic [5:0] f);
    case (f)
      6'h21: return C_ADD_U;  6'h23: return C_SUB_U; 6'h18: return C_MULT;
      6'h19: return C_MUL_U;  6'h24: return C_AND;   6'h25: return C_OR;
      6'h26: return C_XOR;    6'h02: return C_SRL;   6'h00: return C_SLL;
      6'h03: return C_SRA;    6'h2A: return C_SLT;   6'h2B: return C_SLTU;
      6'h10: return C_MFHI;   6'h12: return C_MFLO;  6'h08: return C_JR;
      default: return C_NOP;
    endcase
  endfunction

  function automatic alu_sel_t i_map(input logic [5:0] o);
    case (o)
      6'h09: return C_ADD_U; 6'h0C: return C_AND; 6'h0D: return C_OR;
      6'h0E: return C_XOR;   6'h0A: return C_SLT; default: return C_SLTU;
    endcase
  endfunction

  function automatic alu_sel_t b_map(input logic [5:0] o);
    case (o)
      6'h04: return C_BEQ; 6'h05: return C_BNE; 6'h06: return C_BLEZ; default: return C_BGTZ;
    endcase
  endfunction

  // n wait cycles then a ready cycle; the TMO-th consecutive wait ends in a halt instead.
  task automatic mem_phase(input ovec_t w, input ovec_t d, input int n, input string tag, output bit to);
    to = 1'b0;
    for (int k = 0; k < n; k++) begin
      push(w, 1'b0, rb(), tag);
      if (k + 1 == TMO) begin
        to = 1'b1;
        return;
      end
    end
    push(d, 1'b1, rb(), tag);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic taken,
                       input int fw, input int mw);
    ovec_t v, d;
    bit to;
    int cls;
    alu_sel_t rs;
    m_halt = 1'b0;
    m_ill  = 1'b0;
    v = idle(); v.mem_read = 1'b1; v.src_b = 2'b01; v.opsel = C_ADD_U;
    d = v; d.ir_write = 1'b1; d.pc_en = 1'b1;
    mem_phase(v, d, fw, "fetch", to);
    if (to) begin
      m_halt = 1'b1;
      return;
    end
    cls = op_class(op);
    v = idle(); v.src_b = 2'b11; v.opsel = (cls == 6) ? C_NOP : C_ADD_U;
    push(v, rb(), rb(), "decode");
    case (cls)
      0: begin
        rs = r_map(fn);
        v = idle(); v.src_a = 1'b1; v.opsel = rs;
        v.hlw   = (rs == C_MULT) || (rs == C_MUL_U);
        v.pc_en = (rs == C_JR);
        push(v, rb(), rb(), "r_exec");
        if (rs == C_NOP) begin
          m_halt = TRAP;
          m_ill  = TRAP;
        end else if (!v.hlw && !v.pc_en) begin
          v = idle(); v.opsel = rs; v.reg_write = 1'b1; v.reg_dst = 1'b1;
          push(v, rb(), rb(), "r_wb");
        end
      end
      1: begin
        v = idle(); v.src_a = 1'b1; v.src_b = 2'b10; v.opsel = i_map(op);
        push(v, rb(), rb(), "i_exec");
        v = idle(); v.reg_write = 1'b1;
        push(v, rb(), rb(), "i_wb");
      end
      2: begin
        v = idle(); v.src_a = 1'b1; v.src_b = 2'b10; v.opsel = C_ADD_U;
        push(v, rb(), rb(), "mem_addr");
        v = idle(); v.i_or_d = 1'b1;
        if (op == 6'h23) v.mem_read = 1'b1;
        else v.mem_write = 1'b1;
        mem_phase(v, v, mw, "mem_rw", to);
        if (to) begin
          m_halt = 1'b1;
        end else if (op == 6'h23) begin
          v = idle(); v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
          push(v, rb(), rb(), "mem_wb");
        end
      end
      3: begin
        v = idle(); v.src_a = 1'b1; v.pc_src = 2'b01; v.opsel = b_map(op); v.pc_en = taken;
        push(v, rb(), taken, "branch");
      end
      4: begin
        v = idle(); v.pc_en = 1'b1; v.pc_src = 2'b10;
        v.reg_write = (op == 6'h03); v.jal = (op == 6'h03);
        push(v, rb(), rb(), "jump");
      end
      5: m_halt = 1'b1;
      default: begin
        m_halt = TRAP;
        m_ill  = TRAP;
      end
    endcase
  endtask

  // Each step starts at a falling edge: drive, sample 1 time unit later, move to next falling edge.
  task automatic run_steps(input int limit);
    step_t s;
    int n = 0;
    while (sq.size() > 0 && (limit < 0 || n < limit)) begin
      s = sq.pop_front();
      mem_ready_i    = s.rdy;
      branch_taken_i = s.bt;
      #1;
      check(s.tag, 32'(observe()), 32'(s.e));
      @(negedge clk_i);
      n++;
    end
    sq.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready_i    = rb();
      branch_taken_i = rb();
      ir_opcode_i    = 6'($urandom);
      ir_funct_i     = 6'($urandom);
      #1;
      check("reset", 32'({observe(), state_o}), 32'd0);
      @(negedge clk_i);
    end
    rst_i = 1'b0;
  endtask

  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic taken,
                      input int fw, input int mw, input int cut);
    ovec_t h;
    ir_opcode_i = op;
    ir_funct_i  = fn;
    build(op, fn, taken, fw, mw);
    if (cut >= 0 && cut < sq.size()) begin
      run_steps(cut);
      do_reset();
      return;
    end
    run_steps(-1);
    if (m_halt) begin
      h = idle(); h.halted = 1'b1;
      for (int i = 0; i < 20; i++) push(h, rb(), rb(), "halt");
      run_steps(-1);
      check("halt_id", 32'(state_o == 4'hF), 32'(m_ill));
      do_reset();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [5:0] op, fn;
    int fw, mw, cut;
    rst_i = 1'b1; mem_ready_i = 1'b0; branch_taken_i = 1'b0;
    ir_opcode_i = '0; ir_funct_i = '0;
    do_reset();
    exec(6'h00, 6'h21, 1'b0, 0, 0, -1);
    exec(6'h23, 6'h00, 1'b0, 0, 2, -1);
    exec(6'h04, 6'h00, 1'b1, 0, 0, -1);
    exec(6'h05, 6'h00, 1'b0, 0, 0, -1);
    exec(6'h00, 6'h18, 1'b0, 0, 0, -1);
    exec(6'h00, 6'h10, 1'b0, 0, 0, -1);
    exec(6'h00, 6'h08, 1'b0, 1, 0, -1);
    exec(6'h2B, 6'h00, 1'b0, 1, 1, -1);
    exec(6'h03, 6'h00, 1'b0, 0, 0, -1);
    exec(6'h0A, 6'h00, 1'b0, 0, 0, -1);
    exec(6'h31, 6'h00, 1'b0, 0, 0, -1);
    exec(6'h00, 6'h3D, 1'b0, 0, 0, -1);
    exec(6'h00, 6'h21, 1'b0, 0, 0, 2);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) op = 6'h3F;
      else if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = OP_TAB[$urandom_range(0, 15)];
      fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : FN_TAB[$urandom_range(0, 14)];
      fw  = ($urandom_range(0, 15) == 0) ? TMO : int'($urandom_range(0, 2));
      mw  = ($urandom_range(0, 15) == 0) ? TMO : int'($urandom_range(0, 2));
      cut = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      exec(op, fn, rb(), fw, mw, cut);
    end
    exec(6'h3F, 6'h00, 1'b0, 0, 0, -1);
    exec(6'h00, 6'h21, 1'b0, TMO, 0, -1);
    exec(6'h2B, 6'h00, 1'b0, 0, TMO, -1);
    exec(6'h23, 6'h00, 1'b0, 0, TMO, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle MIPS control FSM; the initiator side of the ALU interface.
- Decodes the instruction-register opcode and funct fields.
- Drives the alu_pkg opsel and all datapath enables (PC, IR, memory, register file, HI/LO).
- Consumes the ALU's branch_taken flag and a memory ready handshake.

Parameters:
- MEM_TIMEOUT, 0: max cycles to wait for mem_ready before entering S_HALT. 0 = wait forever.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- ir_opcode  in  6  IR[31:26]
- ir_funct  in  6  IR[5:0]
- branch_taken  in  1  from ALU, valid during S_BRANCH
- mem_ready  in  1  memory completes current read/write this cycle
- opsel  out  5 (alu_sel_t)  ALU operation select
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  out  1  PC load
- i_or_d  out  1  0=PC addresses memory, 1=ALUOut addresses memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_write  out  1  register-file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  write-back data source is memory
- jump_and_link  out  1  write PC to $31
- hi_lo_write  out  1  latch result_hi/result into HI/LO
- halted  out  1  FSM is in S_HALT
- state_o  out  4  current state encoding (debug)

Behaviour:
- Reset (synchronous, active-high): state <= S_FETCH. While rst=1, every output is 0 and opsel=C_NOP. The first fetch starts the cycle after rst falls. Reset asserted mid-instruction aborts it; no partial write occurs after the reset edge.
- All outputs are Moore (decoded from state, plus the registered opcode/funct), except pc_en in S_BRANCH and mem-stage enables gated by mem_ready. Unlisted outputs are 0 in each state.
- S_FETCH:
  - i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, opsel=C_ADD_U, pc_source=00.
  - Holds until mem_ready=1. In that cycle ir_write=1 and pc_en=1, then go to S_DECODE.
- S_DECODE: alu_src_a=0, alu_src_b=11, opsel=C_ADD_U (precompute branch target). Next state by opcode:
  - 0x00 -> S_R_EXEC
  - 0x09/0x0C/0x0D/0x0E/0x0A/0x0B -> S_I_EXEC
  - 0x23/0x2B -> S_MEM_ADDR
  - 0x04-0x07 -> S_BRANCH
  - 0x02/0x03 -> S_JUMP
  - 0x3F -> S_HALT
  - other -> see Optional Feature
- S_R_EXEC: alu_src_a=1, alu_src_b=00. opsel mapped from funct:
  - 0x21 C_ADD_U, 0x23 C_SUB_U, 0x18 C_MULT, 0x19 C_MUL_U
  - 0x24 C_AND, 0x25 C_OR, 0x26 C_XOR
  - 0x02 C_SRL, 0x00 C_SLL, 0x03 C_SRA
  - 0x2A C_SLT, 0x2B C_SLTU
  - 0x10 C_MFHI, 0x12 C_MFLO, 0x08 C_JR
  - Exits:
    - MULT/MULTU: hi_lo_write=1, then S_FETCH.
    - JR: pc_en=1, pc_source=00, then S_FETCH.
    - Otherwise: S_R_WB.
- S_R_WB: opsel held from S_R_EXEC, reg_write=1, reg_dst=1, mem_to_reg=0, then S_FETCH.
- S_I_EXEC: alu_src_a=1, alu_src_b=10. opsel by opcode:
  - 0x09 C_ADD_U, 0x0C C_AND, 0x0D C_OR, 0x0E C_XOR, 0x0A C_SLT, 0x0B C_SLTU
  - Then S_I_WB.
- S_I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then S_FETCH.
- S_MEM_ADDR: alu_src_a=1, alu_src_b=10, opsel=C_ADD_U. LW -> S_MEM_READ; SW -> S_MEM_WRITE.
- S_MEM_READ: i_or_d=1, mem_read=1. Hold until mem_ready, then S_MEM_WB.
- S_MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then S_FETCH.
- S_MEM_WRITE: i_or_d=1, mem_write=1. Hold until mem_ready, then S_FETCH.
- S_BRANCH:
  - alu_src_a=1, alu_src_b=00, pc_source=01.
  - opsel = C_BEQ/C_BNE/C_BLEZ/C_BGTZ for opcode 0x04/0x05/0x06/0x07.
  - pc_en = branch_taken (same cycle), then S_FETCH.
- S_JUMP: pc_en=1, pc_source=10. For JAL: reg_write=1, jump_and_link=1. Then S_FETCH.
- S_HALT: halted=1, all enables 0, opsel=C_NOP. Exit only via rst.
- Latency in cycles, with zero-wait memory (mem_ready=1 on first request cycle):
  - R-type 4; MULT 3; JR 3; I-type 4
  - LW 5; SW 4; branch 3; J/JAL 3
- Timeout: when MEM_TIMEOUT>0, a wait-cycle counter (clog2(MEM_TIMEOUT+1) bits) resets on entering any memory state. When it reaches MEM_TIMEOUT with mem_ready=0, next state is S_HALT.
- Invariants: mem_read and mem_write are never both 1. The opcode/funct used for decode are registered on the ir_write cycle.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in S_DECODE, or an unknown funct in S_R_EXEC, goes to S_HALT. There halted=1 and a sticky illegal-instruction indication is reflected in state_o=4'hF.
- Undefined: an unknown opcode or funct is a NOP. S_DECODE (or S_R_EXEC) returns to S_FETCH with no writes, opsel=C_NOP.

Test Plan:
- rst=1 for 3 cycles, then release with mem_ready=1 -> all outputs 0 during reset. Cycle 1 after release: mem_read=1, opsel=C_ADD_U, ir_write=1, pc_en=1.
- Fetch ADDU (opcode 0x00, funct 0x21) with mem_ready=1 -> states FETCH, DECODE, R_EXEC (opsel=C_ADD_U), R_WB (reg_write=1, reg_dst=1); 4 cycles total.
- LW (0x23) with mem_ready low for 2 cycles in S_MEM_READ -> mem_read=1, i_or_d=1 held 3 cycles. Then MEM_WB with mem_to_reg=1; total 7 cycles.
- BEQ (0x04) with branch_taken=1, then BNE (0x05) with branch_taken=0 -> pc_en=1, pc_source=01 in the first S_BRANCH; pc_en=0 in the second.
- MULT (funct 0x18) -> hi_lo_write=1 in S_R_EXEC, no S_R_WB, 3 cycles total. MFHI (0x10) -> opsel=C_MFHI then reg_write=1.
- Opcode 0x3F -> halted=1, and it holds for 20 cycles with mem_ready toggling. Opcode 0x31 -> S_HALT with MC_ILLEGAL_TRAP_EN defined, S_FETCH without it. MEM_TIMEOUT=4 with mem_ready stuck 0 -> halted=1 after 4 wait cycles.
